// File: rtl/difftest_irp_event_queue.sv
// difftest_irp_event_queue
//   Multi-hart interrupt-pending change detector for difftest.
//   Each channel (hart) samples its pending vector and raises an event only
//   when the vector differs from the last captured value, or on the first
//   valid sample after reset. Each channel holds one pending event in a slot.
//   A newer event that arrives before the slot is granted replaces the older
//   one and is counted in coalesce_cnt. A round-robin arbiter moves one slot
//   per cycle into a shared circular FIFO. The FIFO drains to the sink over
//   a valid/ready handshake.
//
//   Handshake: the head entry is offered while out_valid=1. It is consumed at
//   a clock edge where out_valid & out_ready. While out_valid & !out_ready,
//   every out_* field holds steady.
//
//   Ports:
//     clock, reset_n   clock; asynchronous active-low reset
//     enable           global detect gate (the arbiter and FIFO keep draining)
//     in_valid/in_irp/in_coreid  per-channel sample, pending vector, core id
//     out_valid/out_ready        FIFO head handshake
//     out_ch/out_coreid/out_irp/out_seq/out_stamp  head entry fields
//     fifo_level       FIFO occupancy
//     coalesce_cnt     saturating count of slot overwrites
//
//   Optional build macro: DIFFTEST_IRP_STAMP_EN
//     When it is defined, a free-running cycle counter is stamped into each
//     entry at the fire edge. When it is undefined, out_stamp is tied to 0.
module difftest_irp_event_queue #(
    parameter int NUM_CH     = 2,
    parameter int IRP_W      = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic [NUM_CH-1:0]                in_valid,
    input  logic [NUM_CH*IRP_W-1:0]          in_irp,
    input  logic [NUM_CH*8-1:0]              in_coreid,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CH_W-1:0]                  out_ch,
    output logic [7:0]                       out_coreid,
    output logic [IRP_W-1:0]                 out_irp,
    output logic [15:0]                      out_seq,
    output logic [31:0]                      out_stamp,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic [15:0]                      coalesce_cnt
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Per-channel change detection and single-entry slots
    logic [IRP_W-1:0] shadow   [NUM_CH];
    logic [IRP_W-1:0] slotIrp  [NUM_CH];
    logic [7:0]       slotCore [NUM_CH];
    logic [IRP_W-1:0] chIrp    [NUM_CH];
    logic [7:0]       chCore   [NUM_CH];
    logic [NUM_CH-1:0] firstSeen, slotFull, fire, coalesce;
    logic [16:0]      coalesceSum;

    // Arbiter and FIFO
    logic [CH_W-1:0]  rrPtr, grantCh;
    logic             grantValid, push, pop;
    logic [15:0]      seq;
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CH_W-1:0]  memCh   [FIFO_DEPTH];
    logic [7:0]       memCore [FIFO_DEPTH];
    logic [IRP_W-1:0] memIrp  [FIFO_DEPTH];
    logic [15:0]      memSeq  [FIFO_DEPTH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            chIrp[c]  = in_irp[c*IRP_W +: IRP_W];
            chCore[c] = in_coreid[c*8 +: 8];
            fire[c]   = enable & in_valid[c] & (~firstSeen[c] | (chIrp[c] != shadow[c]));
        end
    end

    // Round-robin: the first full slot at or after rrPtr wins.
    always_comb begin
        grantValid = 1'b0;
        grantCh    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grantValid && slotFull[(int'(rrPtr) + i) % NUM_CH]) begin
                grantValid = 1'b1;
                grantCh    = CH_W'((int'(rrPtr) + i) % NUM_CH);
            end
        end
    end

    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push      = grantValid & ((fifo_level < LVL_W'(FIFO_DEPTH)) | pop);

    // A fire overwrites a full slot only when that slot is not the one
    // being pushed on this edge. Several channels can overwrite at once.
    always_comb begin
        coalesceSum = {1'b0, coalesce_cnt};
        for (int c = 0; c < NUM_CH; c++) begin
            coalesce[c] = fire[c] & slotFull[c] & ~(push & (grantCh == CH_W'(c)));
            coalesceSum = coalesceSum + 17'(coalesce[c]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c]   <= '0;
                slotIrp[c]  <= '0;
                slotCore[c] <= '0;
            end
            firstSeen    <= '0;
            slotFull     <= '0;
            coalesce_cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (fire[c]) begin
                    shadow[c]    <= chIrp[c];
                    firstSeen[c] <= 1'b1;
                    slotIrp[c]   <= chIrp[c];
                    slotCore[c]  <= chCore[c];
                    slotFull[c]  <= 1'b1;
                end else if (push && (grantCh == CH_W'(c))) begin
                    slotFull[c]  <= 1'b0;
                end
            end
            coalesce_cnt <= coalesceSum[16] ? 16'hFFFF : coalesceSum[15:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rrPtr      <= '0;
            seq        <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifo_level <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                memCh[i]   <= '0;
                memCore[i] <= '0;
                memIrp[i]  <= '0;
                memSeq[i]  <= '0;
            end
        end else begin
            if (push) begin
                memCh[wrPtr]   <= grantCh;
                memCore[wrPtr] <= slotCore[grantCh];
                memIrp[wrPtr]  <= slotIrp[grantCh];
                memSeq[wrPtr]  <= seq;
                wrPtr          <= wrPtr + PTR_W'(1);
                seq            <= seq + 16'd1;
                rrPtr          <= CH_W'((int'(grantCh) + 1) % NUM_CH);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LVL_W'(1);
            end else if (!push && pop) begin
                fifo_level <= fifo_level - LVL_W'(1);
            end
        end
    end

    assign out_ch     = memCh[rdPtr];
    assign out_coreid = memCore[rdPtr];
    assign out_irp    = memIrp[rdPtr];
    assign out_seq    = memSeq[rdPtr];

`ifdef DIFFTEST_IRP_STAMP_EN
    logic [31:0] stampCnt;
    logic [31:0] slotStamp [NUM_CH];
    logic [31:0] memStamp  [FIFO_DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stampCnt <= '0;
            for (int c = 0; c < NUM_CH; c++) slotStamp[c] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) memStamp[i] <= '0;
        end else begin
            stampCnt <= stampCnt + 32'd1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (fire[c]) slotStamp[c] <= stampCnt;
            end
            if (push) memStamp[wrPtr] <= slotStamp[grantCh];
        end
    end

    assign out_stamp = memStamp[rdPtr];
`else
    assign out_stamp = 32'd0;
`endif

endmodule

// File: tb/tb_difftest_irp_event_queue.sv
// Bench for difftest_irp_event_queue.
// A driver process issues stimulus and advances a spec-level reference model.
// The model keeps each channel's pending entry, the arbiter pointer and a FIFO
// count, and pushes every predicted output entry onto exp_q. A monitor pops
// and compares an entry whenever the DUT completes an out_valid/out_ready
// transfer. On every cycle it also checks out_valid, fifo_level and
// coalesce_cnt.
module tb_difftest_irp_event_queue;
  localparam int NUM_CH = 2;
  localparam int IRP_W = 10;
  localparam int FIFO_DEPTH = 8;
  localparam int CH_W = 1;
  localparam int LVL_W = 4;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [7:0]       coreid;
    logic [IRP_W-1:0] irp;
    logic [15:0]      seq;
    logic [31:0]      stamp;
  } ent_t;
  localparam int W = $bits(ent_t);

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n = 1'b0;

  logic                    enable = 1'b0;
  logic [NUM_CH-1:0]       in_valid = '0;
  logic [NUM_CH*IRP_W-1:0] in_irp = '0;
  logic [NUM_CH*8-1:0]     in_coreid = '0;
  logic                    out_ready = 1'b0;
  logic                    out_valid;
  logic [CH_W-1:0]         out_ch;
  logic [7:0]              out_coreid;
  logic [IRP_W-1:0]        out_irp;
  logic [15:0]             out_seq;
  logic [31:0]             out_stamp;
  logic [LVL_W-1:0]        fifo_level;
  logic [15:0]             coalesce_cnt;

  difftest_irp_event_queue #(.NUM_CH(NUM_CH), .IRP_W(IRP_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
    .in_irp(in_irp), .in_coreid(in_coreid), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_coreid(out_coreid), .out_irp(out_irp), .out_seq(out_seq),
    .out_stamp(out_stamp), .fifo_level(fifo_level), .coalesce_cnt(coalesce_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_pops = 0;
  int last_seq = -1;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  logic [IRP_W-1:0] m_shadow[NUM_CH];
  bit               m_seen[NUM_CH];
  bit               m_full[NUM_CH];
  ent_t             m_slot[NUM_CH];
  int               m_rr, m_seq, m_coal, m_level;
  logic [31:0]      m_cyc;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_shadow[c] = '0; m_seen[c] = 0; m_full[c] = 0; m_slot[c] = '0;
    end
    m_rr = 0; m_seq = 0; m_coal = 0; m_level = 0; m_cyc = '0;
    exp_q.delete();
  endtask

  // One clock edge of the specification's behaviour. Inputs are stable here.
  task automatic model_step();
    bit pop;
    int g;
    ent_t e;
    logic [IRP_W-1:0] irp;
    pop = (m_level != 0) && out_ready;
    g = -1;
    for (int i = 0; i < NUM_CH; i++)
      if (g < 0 && m_full[(m_rr + i) % NUM_CH]) g = (m_rr + i) % NUM_CH;
    if (g >= 0 && (m_level < FIFO_DEPTH || pop)) begin
      e = m_slot[g];
      e.seq = 16'(m_seq);
      exp_q.push_back(e);
      m_full[g] = 0;
      m_rr = (g + 1) % NUM_CH;
      m_seq = (m_seq + 1) % 65536;
      m_level++;
    end
    if (pop) m_level--;
    for (int c = 0; c < NUM_CH; c++) begin
      irp = in_irp[c*IRP_W +: IRP_W];
      if (enable && in_valid[c] && (!m_seen[c] || irp != m_shadow[c])) begin
        if (m_full[c] && m_coal < 65535) m_coal++;
        m_slot[c].ch = CH_W'(c);
        m_slot[c].coreid = in_coreid[c*8 +: 8];
        m_slot[c].irp = irp;
        m_slot[c].seq = '0;
`ifdef DIFFTEST_IRP_STAMP_EN
        m_slot[c].stamp = m_cyc;
`else
        m_slot[c].stamp = '0;
`endif
        m_full[c] = 1;
        m_shadow[c] = irp;
        m_seen[c] = 1;
      end
    end
    m_cyc = m_cyc + 32'd1;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step();
    else model_reset();
    #1;
  endtask

  task automatic set_ch(input int c, input bit v, input logic [IRP_W-1:0] irp, input logic [7:0] id);
    in_valid[c] = v;
    in_irp[c*IRP_W +: IRP_W] = irp;
    in_coreid[c*8 +: 8] = id;
  endtask

  task automatic idle(input int n);
    in_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_level", fifo_level, 0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    ent_t e;
    if (reset_n) begin
      check("out_valid", out_valid, m_level != 0);
      check("fifo_level", fifo_level, m_level);
      check("coalesce_cnt", coalesce_cnt, m_coal);
      if (out_valid && out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("unexpected_entry", 1, 0);
        end else begin
          e = ent_t'(exp_q.pop_front());
          check("out_ch", out_ch, e.ch);
          check("out_coreid", out_coreid, e.coreid);
          check("out_irp", out_irp, e.irp);
          check("out_seq", out_seq, e.seq);
          check("out_stamp", out_stamp, e.stamp);
          last_seq = int'(out_seq);
        end
      end
    end
  end

  int base;

  initial begin
    model_reset();
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_ch", out_ch, 0);
    check("reset_out_coreid", out_coreid, 0);
    check("reset_out_irp", out_irp, 0);
    check("reset_out_seq", out_seq, 0);
    check("reset_out_stamp", out_stamp, 0);
    check("reset_fifo_level", fifo_level, 0);
    check("reset_coalesce", coalesce_cnt, 0);
    tick();
    reset_n = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;

    // steady zero vector: one entry only
    base = n_pops;
    for (int i = 0; i < 5; i++) begin
      set_ch(0, 1, 10'h000, 8'h11);
      tick();
    end
    idle(4);
    check("t1_entry_count", n_pops - base, 1);
    check("t1_last_seq", last_seq, 0);

    // two changes in order
    set_ch(0, 1, 10'h001, 8'h11); tick();
    set_ch(0, 1, 10'h003, 8'h11); tick();
    in_valid = '0; tick();
    idle(4);
    check("t2_last_seq", last_seq, 2);

    // simultaneous fires, twice, to exercise round robin
    set_ch(0, 1, 10'h010, 8'h20); set_ch(1, 1, 10'h200, 8'h21); tick();
    idle(4);
    set_ch(0, 1, 10'h020, 8'h20); set_ch(1, 1, 10'h100, 8'h21); tick();
    idle(4);

    // coalescing against a stalled full FIFO
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      set_ch(0, 1, IRP_W'(k + 1), 8'h33);
      tick();
    end
    idle(1);
    check("t4_level_full", fifo_level, 8);
    check("t4_coalesce", coalesce_cnt, 3);
    base = n_pops;
    out_ready = 1'b1;
    idle(15);
    check("t4_drained", n_pops - base, 9);
    check("t4_last_seq", last_seq, 8);

    // reset with entries queued
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_ch(1, 1, IRP_W'(k + 40), 8'h44);
      tick();
    end
    idle(2);
    check("t5_level", fifo_level, 5);
    do_reset();
    out_ready = 1'b1;
    set_ch(1, 1, 10'h155, 8'h45); tick();
    idle(4);
    check("t5_seq_restart", last_seq, 0);

    // stamps five cycles apart, checked through the model
    set_ch(0, 1, 10'h0aa, 8'h50); tick();
    idle(4);
    set_ch(0, 1, 10'h0ab, 8'h50); tick();
    idle(4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_CH; c++)
        set_ch(c, 1'($urandom_range(0, 1)), IRP_W'($urandom_range(0, 3) * 171),
               8'($urandom_range(0, 255)));
      tick();
    end
    enable = 1'b1;
    out_ready = 1'b1;
    idle(30);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
